// File: rtl/screen_blit_engine_pkg.sv
// Shared definitions for the screen blitter: FSM encoding, VGA colour constants
// and the fill-mode selector test.
package screen_blit_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_e;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_BLUE  = 3'b001;

    // Any selector past the last ROM channel paints the latched fill colour.
    function automatic logic is_fill_sel(input int unsigned sel, input int unsigned num_img);
        return sel >= num_img;
    endfunction

endpackage

// File: rtl/screen_blit_engine_delay.sv
// ROM-latency matching shift register carrying {valid, cx, cy}; clr_i drops
// every in-flight pixel in one cycle while leaving coordinate payload untouched.
module blit_delay_line #(
    parameter int STAGES = 1,
    parameter int CX_W   = 8,
    parameter int CY_W   = 8
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            vld_i,
    input  logic [CX_W-1:0] cx_i,
    input  logic [CY_W-1:0] cy_i,
    output logic            vld_o,
    output logic [CX_W-1:0] cx_o,
    output logic [CY_W-1:0] cy_o
);

    logic [STAGES-1:0] vld_q;
    logic [CX_W-1:0]   cx_q [STAGES];
    logic [CY_W-1:0]   cy_q [STAGES];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Coordinates are qualified by vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        cx_q[0] <= cx_i;
        cy_q[0] <= cy_i;
        for (int i = 1; i < STAGES; i++) begin
            cx_q[i] <= cx_q[i-1];
            cy_q[i] <= cy_q[i-1];
        end
    end

    assign vld_o = vld_q[STAGES-1];
    assign cx_o  = cx_q[STAGES-1];
    assign cy_o  = cy_q[STAGES-1];

endmodule

// File: rtl/screen_blit_engine.sv
// Full-screen raster blitter: streams one ROM image channel or a solid fill
// colour to the VGA adapter write port, one pixel per cycle, with a done pulse.
module screen_blit_engine
    import screen_blit_engine_pkg::*;
#(
    parameter int IMG_W    = 240,
    parameter int IMG_H    = 240,
    parameter int X_OFF    = 80,
    parameter int Y_OFF    = 0,
    parameter int COORD_W  = 9,
    parameter int COLOUR_W = 3,
    parameter int NUM_IMG  = 3,
    parameter int SEL_W    = 2,
    parameter int ADDR_W   = 16,
    parameter int ROM_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        abort,
    input  logic [SEL_W-1:0]            sel,
    input  logic [COLOUR_W-1:0]         fill_colour,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [NUM_IMG*COLOUR_W-1:0] rom_data,
    output logic [COORD_W-1:0]          xLoc,
    output logic [COORD_W-1:0]          yLoc,
    output logic [COLOUR_W-1:0]         colour,
    output logic                        plot,
    output logic                        busy,
    output logic                        done
);

    localparam int CX_W = $clog2(IMG_W);
    localparam int CY_W = $clog2(IMG_H);
    localparam int DR_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [CX_W-1:0] CX_LAST    = CX_W'(IMG_W - 1);
    localparam logic [CY_W-1:0] CY_LAST    = CY_W'(IMG_H - 1);
    localparam logic [DR_W-1:0] DRAIN_LAST = DR_W'(ROM_LAT - 1);

    blit_state_e         state_q, state_d;
    logic [CX_W-1:0]     cx_q, cx_d;
    logic [CY_W-1:0]     cy_q, cy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DR_W-1:0]     drain_q, drain_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [COLOUR_W-1:0] fill_q, fill_d;

    logic                last_pix;
    logic                dl_vld;
    logic [CX_W-1:0]     dl_cx;
    logic [CY_W-1:0]     dl_cy;
    logic [COLOUR_W-1:0] pix_col;

    assign last_pix = (cx_q == CX_LAST) && (cy_q == CY_LAST);

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        sel_d   = sel_q;
        fill_d  = fill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = sel;
                    fill_d  = fill_colour;
                    cx_d    = '0;
                    cy_d    = '0;
                    addr_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_pix) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    // Row-major address tracks cy*IMG_W+cx by plain increment.
                    addr_d = addr_q + ADDR_W'(1);
                    if (cx_q == CX_LAST) begin
                        cx_d = '0;
                        cy_d = cy_q + CY_W'(1);
                    end else begin
                        cx_d = cx_q + CX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Cancel wins over everything, including a start in the same cycle.
        if (abort) begin
            state_d = ST_IDLE;
            cx_d    = '0;
            cy_d    = '0;
            addr_d  = '0;
            drain_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            sel_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            sel_q   <= sel_d;
            fill_q  <= fill_d;
        end
    end

    blit_delay_line #(
        .STAGES (ROM_LAT),
        .CX_W   (CX_W),
        .CY_W   (CY_W)
    ) u_delay (
        .clk    (clk),
        .rst_ni (resetn),
        .clr_i  (abort),
        .vld_i  (state_q == ST_RUN),
        .cx_i   (cx_q),
        .cy_i   (cy_q),
        .vld_o  (dl_vld),
        .cx_o   (dl_cx),
        .cy_o   (dl_cy)
    );

    // The last delay stage lines up with the ROM word for the same pixel.
    always_comb begin
        pix_col = COLOUR_W'(COL_BLACK);
        if (is_fill_sel(32'(sel_q), NUM_IMG)) begin
            pix_col = fill_q;
        end else begin
            for (int i = 0; i < NUM_IMG; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    pix_col = rom_data[i*COLOUR_W +: COLOUR_W];
                end
            end
        end
    end

    assign rom_addr = addr_q;
    assign plot     = dl_vld;
    assign xLoc     = dl_vld ? (COORD_W'(X_OFF) + COORD_W'(dl_cx)) : '0;
    assign yLoc     = dl_vld ? (COORD_W'(Y_OFF) + COORD_W'(dl_cy)) : '0;
    assign colour   = dl_vld ? pix_col : COLOUR_W'(COL_BLACK);
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_screen_blit_engine.sv
// Scoreboard bench for screen_blit_engine on a 4x3 image, ROM_LAT 1 and 3.
module tb_screen_blit_engine;
    import screen_blit_engine_pkg::*;

    typedef struct {
        int         cyc;
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int   cyc;
        logic busy;
        logic quiet;
        logic addr0;
    } chk_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic        start_a = 0, abort_a = 0;
    logic [1:0]  sel_a = 0;
    logic [2:0]  fill_a = 0;
    logic [15:0] addr_a;
    logic [8:0]  rom_a;
    logic [8:0]  x_a, y_a;
    logic [2:0]  col_a;
    logic        plot_a, busy_a, done_a;

    logic        start_b = 0, abort_b = 0;
    logic [1:0]  sel_b = 0;
    logic [2:0]  fill_b = 0;
    logic [15:0] addr_b;
    logic [8:0]  rom_b;
    logic [8:0]  x_b, y_b;
    logic [2:0]  col_b;
    logic        plot_b, busy_b, done_b;

    logic [15:0] a_rd;
    logic [15:0] b_rd [3];

    // addr[2:0] for addresses 0..11, worked out by hand.
    logic [2:0] ch1_col [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                 3'd0, 3'd1, 3'd2, 3'd3};

    pix_t pq_a[$], pq_b[$];
    int   dq_a[$], dq_b[$];
    chk_t cq[$];
    pix_t e;
    chk_t r;
    int   dc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: ch0 = ~addr[2:0], ch1 = addr[2:0], ch2 = addr[2:0]^5.
    function automatic logic [8:0] rom_word(input logic [15:0] a);
        logic [2:0] v;
        v = a[2:0];
        return {v ^ 3'b101, v, ~v};
    endfunction

    always @(posedge clk) begin
        a_rd    <= addr_a;
        b_rd[0] <= addr_b;
        b_rd[1] <= b_rd[0];
        b_rd[2] <= b_rd[1];
    end
    assign rom_a = rom_word(a_rd);
    assign rom_b = rom_word(b_rd[2]);

    screen_blit_engine #(.IMG_W(4), .IMG_H(3), .ROM_LAT(1)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .abort(abort_a), .sel(sel_a),
        .fill_colour(fill_a), .rom_addr(addr_a), .rom_data(rom_a), .xLoc(x_a),
        .yLoc(y_a), .colour(col_a), .plot(plot_a), .busy(busy_a), .done(done_a));

    screen_blit_engine #(.IMG_W(4), .IMG_H(3), .ROM_LAT(3)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .abort(abort_b), .sel(sel_b),
        .fill_colour(fill_b), .rom_addr(addr_b), .rom_data(rom_b), .xLoc(x_b),
        .yLoc(y_b), .colour(col_b), .plot(plot_b), .busy(busy_b), .done(done_b));

    // Monitor: pops expectations whenever a DUT presents a plot or done.
    always @(negedge clk) begin
        while (pq_a.size() > 0 && pq_a[0].cyc < cyc) begin
            e = pq_a.pop_front();
            vectors++; miscompares++;
            $display("FAIL pixA_missing want (%0d,%0d) c=%0d at cyc %0d, got no plot", e.x, e.y, e.c, e.cyc);
        end
        while (pq_b.size() > 0 && pq_b[0].cyc < cyc) begin
            e = pq_b.pop_front();
            vectors++; miscompares++;
            $display("FAIL pixB_missing want (%0d,%0d) c=%0d at cyc %0d, got no plot", e.x, e.y, e.c, e.cyc);
        end
        while (dq_a.size() > 0 && dq_a[0] < cyc) begin
            dc = dq_a.pop_front();
            vectors++; miscompares++;
            $display("FAIL doneA_missing want done at cyc %0d, got no done", dc);
        end
        while (dq_b.size() > 0 && dq_b[0] < cyc) begin
            dc = dq_b.pop_front();
            vectors++; miscompares++;
            $display("FAIL doneB_missing want done at cyc %0d, got no done", dc);
        end
        if (plot_a) begin
            vectors++;
            if (pq_a.size() == 0) begin
                miscompares++;
                $display("FAIL pixA_unexpected got (%0d,%0d) c=%0d at cyc %0d, want no plot", x_a, y_a, col_a, cyc);
            end else begin
                e = pq_a.pop_front();
                if (e.cyc != cyc || e.x != x_a || e.y != y_a || e.c != col_a) begin
                    miscompares++;
                    $display("FAIL pixA got (%0d,%0d) c=%0d cyc=%0d, want (%0d,%0d) c=%0d cyc=%0d",
                             x_a, y_a, col_a, cyc, e.x, e.y, e.c, e.cyc);
                end
            end
        end
        if (plot_b) begin
            vectors++;
            if (pq_b.size() == 0) begin
                miscompares++;
                $display("FAIL pixB_unexpected got (%0d,%0d) c=%0d at cyc %0d, want no plot", x_b, y_b, col_b, cyc);
            end else begin
                e = pq_b.pop_front();
                if (e.cyc != cyc || e.x != x_b || e.y != y_b || e.c != col_b) begin
                    miscompares++;
                    $display("FAIL pixB got (%0d,%0d) c=%0d cyc=%0d, want (%0d,%0d) c=%0d cyc=%0d",
                             x_b, y_b, col_b, cyc, e.x, e.y, e.c, e.cyc);
                end
            end
        end
        if (done_a) begin
            vectors++;
            if (dq_a.size() == 0) begin
                miscompares++;
                $display("FAIL doneA_unexpected got done at cyc %0d, want none", cyc);
            end else begin
                dc = dq_a.pop_front();
                if (dc != cyc) begin
                    miscompares++;
                    $display("FAIL doneA got cyc %0d, want cyc %0d", cyc, dc);
                end
            end
        end
        if (done_b) begin
            vectors++;
            if (dq_b.size() == 0) begin
                miscompares++;
                $display("FAIL doneB_unexpected got done at cyc %0d, want none", cyc);
            end else begin
                dc = dq_b.pop_front();
                if (dc != cyc) begin
                    miscompares++;
                    $display("FAIL doneB got cyc %0d, want cyc %0d", cyc, dc);
                end
            end
        end
        while (cq.size() > 0 && cq[0].cyc <= cyc) begin
            r = cq.pop_front();
            vectors++;
            if (r.cyc != cyc) begin
                miscompares++;
                $display("FAIL stateA_check for cyc %0d evaluated at cyc %0d", r.cyc, cyc);
            end else if (busy_a != r.busy ||
                         (r.quiet && {plot_a, done_a, x_a, y_a, col_a} != '0) ||
                         (r.addr0 && addr_a != 16'd0)) begin
                miscompares++;
                $display("FAIL stateA cyc %0d got busy=%0b plot=%0b done=%0b x=%0d y=%0d c=%0d addr=%0d, want busy=%0b quiet=%0b addr0=%0b",
                         cyc, busy_a, plot_a, done_a, x_a, y_a, col_a, addr_a, r.busy, r.quiet, r.addr0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_chk(input int c, input logic b, input logic q, input logic a0);
        chk_t k;
        k.cyc = c; k.busy = b; k.quiet = q; k.addr0 = a0;
        cq.push_back(k);
    endtask

    // mode 0..2 = ROM channel, 3 = fill colour fc.
    task automatic push_frame(input logic use_b, input int j, input int lat, input int npix,
                              input logic with_done, input int mode, input logic [2:0] fc);
        pix_t p;
        for (int n = 0; n < npix; n++) begin
            p.cyc = j + 1 + n + lat;
            p.x   = 9'(80 + n % 4);
            p.y   = 9'(n / 4);
            case (mode)
                0:       p.c = ~ch1_col[n];
                1:       p.c = ch1_col[n];
                2:       p.c = ch1_col[n] ^ 3'b101;
                default: p.c = fc;
            endcase
            if (use_b) pq_b.push_back(p);
            else       pq_a.push_back(p);
        end
        if (with_done) begin
            if (use_b) dq_b.push_back(j + 1 + 12 + lat);
            else       dq_a.push_back(j + 1 + 12 + lat);
        end
    endtask

    initial begin
        int j;
        // Reset state
        tick();
        push_chk(cyc, 1'b0, 1'b1, 1'b1);
        tick();
        resetn = 1'b1;
        repeat (2) tick();

        // Image 1, ROM_LAT 1; sel changes after start must not matter
        j = cyc; start_a = 1; sel_a = 2'd1;
        push_frame(0, j, 1, 12, 1, 1, 3'd0);
        push_chk(j, 1'b0, 1'b1, 1'b1);
        push_chk(j + 1, 1'b1, 1'b1, 1'b1);
        push_chk(j + 13, 1'b1, 1'b0, 1'b0);
        push_chk(j + 14, 1'b0, 1'b0, 1'b0);
        push_chk(j + 15, 1'b0, 1'b1, 1'b0);
        tick(); start_a = 0; sel_a = 2'd2;
        repeat (20) tick();

        // Fill mode; fill_colour change after start ignored
        j = cyc; start_a = 1; sel_a = 2'd3; fill_a = COL_BLUE;
        push_frame(0, j, 1, 12, 1, 3, COL_BLUE);
        tick(); start_a = 0; fill_a = 3'b110; sel_a = 2'd0;
        repeat (20) tick();

        // Start re-pulsed mid-frame and during DONE: ignored
        j = cyc; start_a = 1; sel_a = 2'd1;
        push_frame(0, j, 1, 12, 1, 1, 3'd0);
        tick(); start_a = 0;
        repeat (4) tick();
        start_a = 1; sel_a = 2'd3;
        tick(); start_a = 0;
        while (cyc < j + 14) tick();
        start_a = 1;
        tick(); start_a = 0;
        push_chk(j + 17, 1'b0, 1'b1, 1'b0);
        repeat (6) tick();

        // Abort after the 5th plot (channel 0)
        j = cyc; start_a = 1; sel_a = 2'd0;
        push_frame(0, j, 1, 5, 0, 0, 3'd0);
        push_chk(j + 6, 1'b1, 1'b0, 1'b0);
        push_chk(j + 7, 1'b0, 1'b1, 1'b1);
        tick(); start_a = 0;
        repeat (5) tick();
        abort_a = 1;
        tick(); abort_a = 0;
        repeat (15) tick();

        // abort and start in the same idle cycle: abort wins
        j = cyc; start_a = 1; abort_a = 1; sel_a = 2'd1;
        push_chk(j + 1, 1'b0, 1'b1, 1'b1);
        push_chk(j + 3, 1'b0, 1'b1, 1'b1);
        tick(); start_a = 0; abort_a = 0;
        repeat (5) tick();

        // Fresh frame after abort starts at (80,0); channel 2
        j = cyc; start_a = 1; sel_a = 2'd2;
        push_frame(0, j, 1, 12, 1, 2, 3'd0);
        tick(); start_a = 0;
        repeat (20) tick();

        // Asynchronous reset mid-frame
        j = cyc; start_a = 1; sel_a = 2'd1;
        push_frame(0, j, 1, 2, 0, 1, 3'd0);
        push_chk(j + 4, 1'b0, 1'b1, 1'b1);
        for (int k = 7; k <= 10; k++) push_chk(j + k, 1'b0, 1'b1, 1'b1);
        tick(); start_a = 0;
        repeat (3) tick();
        #1 resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        repeat (10) tick();

        // ROM_LAT 3: image 1, then fill
        j = cyc; start_b = 1; sel_b = 2'd1;
        push_frame(1, j, 3, 12, 1, 1, 3'd0);
        tick(); start_b = 0;
        repeat (22) tick();
        j = cyc; start_b = 1; sel_b = 2'd3; fill_b = COL_BLUE;
        push_frame(1, j, 3, 12, 1, 3, COL_BLUE);
        tick(); start_b = 0; fill_b = 3'b111;
        repeat (25) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
